handshake_req_tx: RTL and testbench

//   Transmit end of a 4-phase req/ack handshake to a block on an unrelated clock or off-chip.

---
 rtl/handshake_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/handshake_req_tx.sv | 166 ++++++++++++++++
 tb/tb_handshake_req_tx.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/handshake_pkg.sv
// Shared types and defaults for the 4-phase request transmitter.
// Optional abort-on-timeout is enabled by defining HANDSHAKE_TIMEOUT_EN.
package handshake_pkg;

    localparam int unsigned DefaultWidth   = 8;
    localparam int unsigned DefaultTimeout = 255;

    // ARM parks a captured word while a stale ack is still high, so req never
    // rises into an ack that belongs to an earlier transfer.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        REQ     = 2'd2,
        RELEASE = 2'd3
    } hs_state_t;

    // Width of a counter able to hold 0..timeout.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; both stages clear on reset.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out
);

    logic meta_q;
    logic sync_q;

    // Shift the asynchronous level through two stages to settle metastability.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= in;
            sync_q <= meta_q;
        end
    end

    assign out = sync_q;

endmodule

// File: rtl/handshake_req_tx.sv
// Transmit side of a 4-phase req/ack handshake towards an unrelated clock domain.
// A word is captured on an accepted send and held on data_out while req_out is up.
// Optional feature: define HANDSHAKE_TIMEOUT_EN to abort a stalled handshake after
// TIMEOUT cycles in REQ or RELEASE; otherwise the FSM waits indefinitely.
module handshake_req_tx
    import handshake_pkg::*;
#(
    parameter int unsigned WIDTH   = DefaultWidth,
    parameter int unsigned TIMEOUT = DefaultTimeout
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             send,
    input  logic [WIDTH-1:0] send_data,
    input  logic             ack_in,
    output logic             req_out,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done,
    output logic             dropped,
    output logic             timeout_err
);

    logic ack_s;

    hs_state_t        state_q, state_d;
    logic             req_q, req_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             done_q, done_d;
    logic             dropped_q, dropped_d;

    // FSM <-> timeout counter interface.
    logic             enter_wait;  // entering REQ or RELEASE this cycle
    logic             abort;       // handshake abandoned this cycle
    logic             tmo_hit;     // wait budget exhausted in the current state

    sync_2ff u_ack_sync (
        .clk   (clk),
        .reset (reset),
        .in    (ack_in),
        .out   (ack_s)
    );

    // Next-state and registered-output decode; all decisions use the synchronized ack.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        data_d     = data_q;
        done_d     = 1'b0;
        dropped_d  = send && (state_q != IDLE);
        enter_wait = 1'b0;
        abort      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (send) begin
                    data_d = send_data;
                    if (ack_s) begin
                        state_d = ARM;
                    end else begin
                        state_d    = REQ;
                        req_d      = 1'b1;
                        enter_wait = 1'b1;
                    end
                end
            end
            ARM: begin
                if (!ack_s) begin
                    state_d    = REQ;
                    req_d      = 1'b1;
                    enter_wait = 1'b1;
                end
            end
            REQ: begin
                // A real ack wins over a simultaneous timeout.
                if (ack_s) begin
                    state_d    = RELEASE;
                    req_d      = 1'b0;
                    enter_wait = 1'b1;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    abort   = 1'b1;
                end
            end
            RELEASE: begin
                if (!ack_s) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    abort   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State, held word and pulse registers; reset also drops req mid-handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            data_q    <= '0;
            done_q    <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            data_q    <= data_d;
            done_q    <= done_d;
            dropped_q <= dropped_d;
        end
    end

`ifdef HANDSHAKE_TIMEOUT_EN
    localparam int unsigned    CntW    = cnt_width(TIMEOUT);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            terr_q, terr_d;

    // Count cycles spent waiting; the count restarts on every entry to REQ/RELEASE.
    always_comb begin
        cnt_d  = cnt_q;
        terr_d = abort;
        if (enter_wait) begin
            cnt_d = '0;
        end else if ((state_q == REQ) || (state_q == RELEASE)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Counter and abort pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            terr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            terr_q <= terr_d;
        end
    end

    // Expiry after TIMEOUT full cycles in the waiting state.
    assign tmo_hit     = ((state_q == REQ) || (state_q == RELEASE)) && (cnt_q == CntLast);
    assign timeout_err = terr_q;
`else
    logic unused_cfg;

    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
    assign unused_cfg  = enter_wait ^ abort ^ (TIMEOUT == 0);
`endif

    assign req_out  = req_q;
    assign data_out = data_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign dropped  = dropped_q;

endmodule

// File: tb/tb_handshake_req_tx.sv
// Self-checking bench for handshake_req_tx: directed scenarios followed by a randomized
// run, all compared cycle by cycle against a behavioural model of the transfer rules.
module tb_handshake_req_tx;

    localparam int unsigned W          = 8;
    localparam int unsigned TB_TIMEOUT = 10;
`ifdef HANDSHAKE_TIMEOUT_EN
    localparam bit TmoEn = 1'b1;
`else
    localparam bit TmoEn = 1'b0;
`endif

    localparam int M_IDLE   = 0;  // free, waiting for a send
    localparam int M_STALE  = 1;  // word captured, old ack still visible
    localparam int M_WAIT1  = 2;  // req up, waiting for ack rise
    localparam int M_WAIT0  = 3;  // req down, waiting for ack fall

    logic         clk = 1'b0;
    logic         reset;
    logic         send;
    logic [W-1:0] send_data;
    logic         ack_in;
    logic         req_out;
    logic [W-1:0] data_out;
    logic         busy;
    logic         done;
    logic         dropped;
    logic         timeout_err;

    int    n_assert = 0;
    int    n_fail   = 0;
    string step     = "init";

    // Behavioural reference state.
    int           ph;
    logic         m_req;
    logic [W-1:0] m_data;
    logic         m_done, m_drop, m_terr;
    logic         ack_hist[$];  // ack_in samples of the previous two edges, oldest first
    int           edge_no = 0;
    int           entry_edge = 0;
    logic         saw_done;

    handshake_req_tx #(
        .WIDTH   (W),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .send        (send),
        .send_data   (send_data),
        .ack_in      (ack_in),
        .req_out     (req_out),
        .data_out    (data_out),
        .busy        (busy),
        .done        (done),
        .dropped     (dropped),
        .timeout_err (timeout_err)
    );

    always #50 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: observed %0h expected %0h", step, tag, obs, exp);
        end
    endtask

    // Advance the reference by one clock edge using the inputs about to be sampled.
    // The FSM reacts to the ack level sampled two edges earlier.
    task automatic model_edge();
        logic seen;
        edge_no++;
        if (reset) begin
            ph = M_IDLE; m_req = 0; m_data = '0; m_done = 0; m_drop = 0; m_terr = 0;
            ack_hist = '{1'b0, 1'b0};
            return;
        end
        seen   = ack_hist[0];
        m_done = 0;
        m_terr = 0;
        m_drop = send && (ph != M_IDLE);
        case (ph)
            M_IDLE: if (send) begin
                m_data = send_data;
                if (seen) ph = M_STALE;
                else begin ph = M_WAIT1; m_req = 1; entry_edge = edge_no; end
            end
            M_STALE: if (!seen) begin ph = M_WAIT1; m_req = 1; entry_edge = edge_no; end
            M_WAIT1: begin
                if (seen) begin ph = M_WAIT0; m_req = 0; entry_edge = edge_no; end
                else if (TmoEn && (edge_no - entry_edge == TB_TIMEOUT)) begin
                    ph = M_IDLE; m_req = 0; m_terr = 1;
                end
            end
            default: begin
                if (!seen) begin ph = M_IDLE; m_done = 1; end
                else if (TmoEn && (edge_no - entry_edge == TB_TIMEOUT)) begin
                    ph = M_IDLE; m_req = 0; m_terr = 1;
                end
            end
        endcase
        void'(ack_hist.pop_front());
        ack_hist.push_back(ack_in);
    endtask

    // One clock: update the model, then compare every output 1 time unit after the edge.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("req_out", req_out, m_req);
        chk("data_out", data_out, m_data);
        chk("busy", busy, ph != M_IDLE);
        chk("done", done, m_done);
        chk("dropped", dropped, m_drop);
        chk("timeout_err", timeout_err, m_terr);
        if (done === 1'b1) saw_done = 1'b1;
    endtask

    // Receiver side of a normal completion: raise ack, then drop it.
    task automatic finish_hs();
        saw_done = 1'b0;
        ack_in = 1'b1;
        repeat (4) tick();
        ack_in = 1'b0;
        repeat (4) tick();
        chk("done_seen", saw_done, 1'b1);
    endtask

    initial begin
        int dly;
        ack_hist  = '{1'b0, 1'b0};
        reset     = 1'b1;
        send      = 1'b0;
        send_data = '0;
        ack_in    = 1'b0;

        step = "reset";
        repeat (2) tick();
        chk("rst_req", req_out, 1'b0);
        chk("rst_busy", busy, 1'b0);
        reset = 1'b0;
        repeat (2) tick();
        chk("idle_req", req_out, 1'b0);

        step = "basic";
        send = 1'b1; send_data = 8'hA5;
        tick();
        send = 1'b0;
        chk("req_up", req_out, 1'b1);
        chk("data_a5", data_out, 8'hA5);
        repeat (3) tick();
        ack_in = 1'b1;  // sampled next edge, then two flop stages before the FSM sees it
        repeat (2) tick();
        chk("req_hold", req_out, 1'b1);
        tick();
        chk("req_fall", req_out, 1'b0);
        ack_in = 1'b0;
        repeat (2) tick();
        chk("done_early", done, 1'b0);
        tick();
        chk("done_pulse", done, 1'b1);
        chk("done_busy", busy, 1'b0);
        tick();

        step = "drop";
        send = 1'b1; send_data = 8'hA5;
        tick();
        send = 1'b0;
        tick();
        send = 1'b1; send_data = 8'h3C;
        tick();
        send = 1'b0;
        chk("dropped", dropped, 1'b1);
        chk("data_kept", data_out, 8'hA5);
        tick();
        chk("drop_clear", dropped, 1'b0);
        finish_hs();

        step = "stale";
        ack_in = 1'b1;
        repeat (3) tick();
        send = 1'b1; send_data = 8'h5A;
        tick();
        send = 1'b0;
        chk("arm_busy", busy, 1'b1);
        chk("arm_req", req_out, 1'b0);
        repeat (3) tick();
        chk("arm_hold", req_out, 1'b0);
        ack_in = 1'b0;
        repeat (2) tick();
        chk("arm_wait", req_out, 1'b0);
        tick();
        chk("arm_req_up", req_out, 1'b1);
        chk("arm_data", data_out, 8'h5A);
        finish_hs();

        step = "midreset";
        send = 1'b1; send_data = 8'hC3;
        tick();
        send = 1'b0;
        tick();
        chk("pre_rst_req", req_out, 1'b1);
        reset = 1'b1;
        tick();
        chk("rst_req_drop", req_out, 1'b0);
        chk("rst_busy_drop", busy, 1'b0);
        chk("rst_no_done", done, 1'b0);
        reset = 1'b0;
        tick();
        chk("rst_no_done2", done, 1'b0);

        step = "timeout";
        send = 1'b1; send_data = 8'h77;
        tick();
        send = 1'b0;
`ifdef HANDSHAKE_TIMEOUT_EN
        for (int k = 1; k <= int'(TB_TIMEOUT); k++) begin
            tick();
            if (k < int'(TB_TIMEOUT)) chk("tmo_wait_req", req_out, 1'b1);
        end
        chk("tmo_req_fall", req_out, 1'b0);
        chk("tmo_err", timeout_err, 1'b1);
        tick();
        chk("tmo_err_pulse", timeout_err, 1'b0);
        send = 1'b1; send_data = 8'h88;
        tick();
        send = 1'b0;
        chk("tmo_resend", req_out, 1'b1);
        chk("tmo_resend_d", data_out, 8'h88);
`else
        repeat (3 * TB_TIMEOUT) tick();
        chk("no_tmo_req", req_out, 1'b1);
        chk("no_tmo_err", timeout_err, 1'b0);
`endif
        finish_hs();

        // Randomized traffic: receiver follows req with random latency, plus
        // occasional ack glitches (stale acks) and rare resets.
        step = "random";
        dly = 0;
        for (int c = 0; c < 4000; c++) begin
            send      = ($urandom_range(0, 5) == 0);
            send_data = W'($urandom);
            reset     = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 49) == 0) ack_in = ~ack_in;
            else if (ack_in != req_out) begin
                if (dly == 0) ack_in = req_out;
                else dly--;
            end else dly = $urandom_range(0, 13);
            tick();
        end
        reset = 1'b0;
        send  = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
